// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Execute-stage multiply/divide unit for the P6 pipeline. Owns the
//   architectural HI/LO registers, runs multi-cycle mult/multu/div/divu,
//   single-cycle mthi/mtlo writes and combinational mfhi/mflo reads, and
//   raises the MDU stall request toward the hazard logic.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   start    in   one-cycle launch pulse for MDOp 1..4
//   MDOp     in   [3:0] 0 none,1 mult,2 multu,3 div,4 divu,
//                        5 mthi,6 mtlo,7 mfhi,8 mflo
//   A, B     in   [31:0] forwarded rs / rt operands
//   MDReq    in   Decode-stage instruction needs the MDU
//   busy     out  multi-cycle operation in flight
//   MDStall  out  stall request to the hazard unit
//   HI, LO   out  [31:0] architectural HI / LO
//   MDOut    out  [31:0] mfhi / mflo read data
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDReq,
  output logic        busy,
  output logic        MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        pend_hi_q, pend_lo_q;
  logic               pend_wr_q;   // pending result may be committed (not a /0)

  // -------------------------------------------------------------------------
  // Operand decode
  // -------------------------------------------------------------------------
  logic is_mul, is_div, is_signed, is_md;

  assign is_mul    = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div    = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
  assign is_md     = is_mul || is_div;

  // Signed ops run on magnitudes through one shared unsigned multiplier and
  // divider; signs are re-applied afterwards. This also makes the
  // 0x80000000 / -1 case fall out naturally (|A| = 0x80000000, quotient
  // stays 0x80000000, remainder 0) with no overflowing signed divide.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign a_neg = is_signed & A[31];
  assign b_neg = is_signed & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;

  // -------------------------------------------------------------------------
  // Multiply
  // -------------------------------------------------------------------------
  logic [63:0] prod_mag, prod;

  assign prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
  assign prod     = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;

  // -------------------------------------------------------------------------
  // Divide: truncating quotient, remainder follows the dividend's sign.
  // -------------------------------------------------------------------------
  logic        div_zero;
  logic [31:0] dvsr, quo_mag, rem_mag, quo, rem;

  assign div_zero = (B == 32'd0);
  // Keep the divider operand non-zero so the datapath never sees x/0;
  // the result is discarded at commit anyway.
  assign dvsr     = div_zero ? 32'd1 : b_mag;
  assign quo_mag  = a_mag / dvsr;
  assign rem_mag  = a_mag % dvsr;
  assign quo      = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem      = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  // Next pending result captured at launch
  logic [31:0]      res_hi_d, res_lo_d;
  logic             res_wr_d;
  logic [CNT_W-1:0] res_cnt_d;

  always_comb begin
    res_hi_d  = prod[63:32];
    res_lo_d  = prod[31:0];
    res_wr_d  = 1'b1;
    res_cnt_d = CNT_W'(MULT_CYCLES);
    if (is_div) begin
      res_hi_d  = rem;
      res_lo_d  = quo;
      res_wr_d  = ~div_zero;
      res_cnt_d = CNT_W'(DIV_CYCLES);
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM + HI/LO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_md) begin
            state_q   <= S_RUN;
            cnt_q     <= res_cnt_d;
            pend_hi_q <= res_hi_d;
            pend_lo_q <= res_lo_d;
            pend_wr_q <= res_wr_d;
          end else if (MDOp == OP_MTHI) begin
            hi_q <= A;
          end else if (MDOp == OP_MTLO) begin
            lo_q <= A;
          end
        end
        S_RUN: begin
          // start, mthi and mtlo are all ignored while running
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy    = (state_q == S_RUN);
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign MDStall = MDReq & (start | busy);
  // Reads show the current (possibly stale) HI/LO; the stall covers hazards.
  assign MDOut   = (MDOp == OP_MFHI) ? hi_q :
                   (MDOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
